// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit memory stage.
//   - Funct3 load/store size/sign codes
//   - two-state access FSM encoding
//   - upper bound on configurable wait states
package lsu_pkg;

  localparam int unsigned MAX_WAIT_STATES = 7;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: DEPTH_WORDS x 32 data array, byte-write-enable, async read.
// Ports:
//   clk   - write clock (rising edge)
//   addr  - word index
//   we    - per-byte write enable, bit i writes bits [8i+7:8i]
//   wdata - write data, already lane-aligned
//   rdata - combinational read of mem[addr]
// Contents have no reset.
module lsu_data_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lsu_memory_stage.sv
// lsu_memory_stage: M-stage load/store unit with optional wait states.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   ValidM      - M-stage instruction valid
//   MemReadM    - load request
//   MemWriteM   - store request
//   Funct3M     - access size/sign
//   ALUResultM  - byte address
//   WriteDataM  - store data (low lanes for sub-word stores)
//   ReadDataM   - extended load result, 0 outside load completion
//   StallM      - hold M and earlier stages
//   FaultM      - access rejected (misaligned, out of range, illegal code)
// Outputs are combinational so a zero-wait access completes in its own cycle.
module lsu_memory_stage
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM
);

  localparam int unsigned WS       = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam int unsigned CNT_W    = (WS > 0) ? $clog2(WS + 1) : 1;
  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_INIT = (WS > 0) ? WS - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             latch_en;
  logic             use_q;
  logic             complete;

  // Latched request (only in-range addresses are ever latched)
  logic [AW+1:0]    addr_q;
  logic [2:0]       f3_q;
  logic [31:0]      wdata_q;
  logic             write_q;

  logic             access, legal_f3, misaligned, out_of_range, fault;

  logic [AW+1:0]    cur_addr;
  logic [2:0]       cur_f3;
  logic [31:0]      cur_wdata;
  logic             cur_write;

  logic [3:0]       be, we;
  logic [31:0]      wlane, rdata_word, load_val;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign access = ValidM & (MemReadM | MemWriteM);

  // Fault decode on the live request
  always_comb begin
    legal_f3 = 1'b0;
    if (MemReadM && MemWriteM) begin
      legal_f3 = 1'b0;
    end else if (MemWriteM) begin
      case (Funct3M)
        F3_SB, F3_SH, F3_SW: legal_f3 = 1'b1;
        default:             legal_f3 = 1'b0;
      endcase
    end else begin
      case (Funct3M)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal_f3 = 1'b1;
        default:                             legal_f3 = 1'b0;
      endcase
    end
    misaligned   = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                   ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
    out_of_range = ({1'b0, ALUResultM[31:2]} >= 31'(DEPTH_WORDS));
    fault        = access && (!legal_f3 || misaligned || out_of_range);
  end

  // State register and request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch_en) begin
        addr_q  <= ALUResultM[AW+1:0];
        f3_q    <= Funct3M;
        wdata_q <= WriteDataM;
        write_q <= MemWriteM;
      end
    end
  end

  // Next state, stall, fault and completion strobe
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    use_q      = 1'b0;
    complete   = 1'b0;
    StallM     = 1'b0;
    FaultM     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (fault) begin
            FaultM = 1'b1;
          end else if (WS == 0) begin
            complete = 1'b1;
          end else begin
            StallM     = 1'b1;
            latch_en   = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        use_q = 1'b1;
        if (cnt != '0) begin
          StallM   = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
    // Reset suppresses every visible effect, including an in-flight write
    if (rst) begin
      StallM   = 1'b0;
      FaultM   = 1'b0;
      complete = 1'b0;
      latch_en = 1'b0;
    end
  end

  // Completing request: live inputs for zero-wait, latched copy from BUSY
  always_comb begin
    cur_addr  = use_q ? addr_q  : ALUResultM[AW+1:0];
    cur_f3    = use_q ? f3_q    : Funct3M;
    cur_wdata = use_q ? wdata_q : WriteDataM;
    cur_write = use_q ? write_q : MemWriteM;
  end

  // Store lane placement and byte enables
  always_comb begin
    case (cur_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = cur_wdata;
      end
    endcase
    we = (complete && cur_write) ? be : 4'b0000;
  end

  lsu_data_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (cur_addr[AW+1:2]),
    .we    (we),
    .wdata (wlane),
    .rdata (rdata_word)
  );

  // Load lane select and extension
  always_comb begin
    byte_sel = 8'(rdata_word >> {cur_addr[1:0], 3'b000});
    half_sel = cur_addr[1] ? rdata_word[31:16] : rdata_word[15:0];
    case (cur_f3)
      F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_val = {24'h0, byte_sel};
      F3_LHU:  load_val = {16'h0, half_sel};
      default: load_val = rdata_word;
    endcase
    ReadDataM = (complete && !cur_write) ? load_val : 32'h0;
  end

endmodule

// File: tb/tb_lsu_memory_stage.sv
// Directed bench: one zero-wait instance and one three-wait instance,
// sharing request fields but with independent valid and reset.
module tb_lsu_memory_stage;

  logic        clk;
  logic        rst0, rst3;
  logic        valid0, valid3;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata3;
  logic        stall0, stall3, fault0, fault3;

  int errors = 0;
  int checks = 0;
  int stall0_seen = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  lsu_memory_stage #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .ValidM(valid0), .MemReadM(mem_read), .MemWriteM(mem_write),
    .Funct3M(funct3), .ALUResultM(addr), .WriteDataM(wdata),
    .ReadDataM(rdata0), .StallM(stall0), .FaultM(fault0)
  );

  lsu_memory_stage #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .ValidM(valid3), .MemReadM(mem_read), .MemWriteM(mem_write),
    .Funct3M(funct3), .ALUResultM(addr), .WriteDataM(wdata),
    .ReadDataM(rdata3), .StallM(stall3), .FaultM(fault3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stall0 === 1'b1) stall0_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = d;
  endtask

  // Single-cycle access on the zero-wait instance
  task automatic acc0(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_fault);
    set_req(rd, wr, f3, a, d);
    valid0 = 1'b1;
    @(negedge clk);
    check({tag, "/rdata"}, rdata0, exp_rd);
    check({tag, "/fault"}, 32'(fault0), 32'(exp_fault));
    check({tag, "/stall"}, 32'(stall0), 32'h0);
    @(posedge clk); #1;
    valid0 = 1'b0;
  endtask

  // Four-cycle access on the three-wait instance; request is scrambled while busy
  task automatic acc3(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    set_req(rd, wr, f3, a, d);
    valid3 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("%s/stall_c%0d", tag, c), 32'(stall3), (c < 4) ? 32'h1 : 32'h0);
      check($sformatf("%s/rdata_c%0d", tag, c), rdata3, (c == 4) ? exp_rd : 32'h0);
      @(posedge clk); #1;
      if (c == 1) set_req(1'b0, 1'b1, SW, 32'h44, 32'hFFFF_FFFF);
    end
    valid3 = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst0 = 1'b1; rst3 = 1'b1;
    valid0 = 1'b1; valid3 = 1'b1;
    set_req(1'b1, 1'b0, LW, 32'h10, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/stall3", 32'(stall3), 32'h0);
    check("rst/fault0", 32'(fault0), 32'h0);
    check("rst/rdata0", rdata0, 32'h0);
    check("rst/rdata3", rdata3, 32'h0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst3 = 1'b0;
    valid0 = 1'b0; valid3 = 1'b0;

    // ---- zero wait states ----
    acc0("sw10",   1'b0, 1'b1, SW,  32'h10, 32'h8000_00F0, 32'h0, 1'b0);
    acc0("lb10",   1'b1, 1'b0, LB,  32'h10, 32'h0, 32'hFFFF_FFF0, 1'b0);
    acc0("lbu10",  1'b1, 1'b0, LBU, 32'h10, 32'h0, 32'h0000_00F0, 1'b0);
    acc0("sw00",   1'b0, 1'b1, SW,  32'h00, 32'h0, 32'h0, 1'b0);
    acc0("sw20",   1'b0, 1'b1, SW,  32'h20, 32'h1122_3344, 32'h0, 1'b0);
    acc0("sh22",   1'b0, 1'b1, SH,  32'h22, 32'hAAAA_BEEF, 32'h0, 1'b0);
    acc0("lw20",   1'b1, 1'b0, LW,  32'h20, 32'h0, 32'hBEEF_3344, 1'b0);
    acc0("lh22",   1'b1, 1'b0, LH,  32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0);
    acc0("lhu22",  1'b1, 1'b0, LHU, 32'h22, 32'h0, 32'h0000_BEEF, 1'b0);
    acc0("lb23",   1'b1, 1'b0, LB,  32'h23, 32'h0, 32'hFFFF_FFBE, 1'b0);
    acc0("lbu21",  1'b1, 1'b0, LBU, 32'h21, 32'h0, 32'h0000_0033, 1'b0);
    acc0("sb21",   1'b0, 1'b1, SB,  32'h21, 32'hFFFF_FF5A, 32'h0, 1'b0);
    acc0("lw20b",  1'b1, 1'b0, LW,  32'h20, 32'h0, 32'hBEEF_5A44, 1'b0);
    // faults
    acc0("f_lw11",  1'b1, 1'b0, LW,     32'h11,  32'h0, 32'h0, 1'b1);
    acc0("f_sh03",  1'b0, 1'b1, SH,     32'h03,  32'hBEEF, 32'h0, 1'b1);
    acc0("f_lw100", 1'b1, 1'b0, LW,     32'h100, 32'h0, 32'h0, 1'b1);
    acc0("f_sw100", 1'b0, 1'b1, SW,     32'h100, 32'hDEAD_BEEF, 32'h0, 1'b1);
    acc0("f_f3011", 1'b1, 1'b0, 3'b011, 32'h20,  32'h0, 32'h0, 1'b1);
    acc0("f_st100", 1'b0, 1'b1, 3'b100, 32'h20,  32'h0, 32'h0, 1'b1);
    acc0("f_rdwr",  1'b1, 1'b1, SW,     32'h20,  32'h0, 32'h0, 1'b1);
    acc0("lw00",   1'b1, 1'b0, LW,  32'h00, 32'h0, 32'h0, 1'b0);
    acc0("lw20c",  1'b1, 1'b0, LW,  32'h20, 32'h0, 32'hBEEF_5A44, 1'b0);
    // no access: misaligned address must not fault without ValidM
    set_req(1'b1, 1'b0, LW, 32'h11, 32'h0);
    @(negedge clk);
    check("idle/fault0", 32'(fault0), 32'h0);
    check("idle/rdata0", rdata0, 32'h0);
    check("ws0/never_stall", 32'(stall0_seen), 32'h0);
    @(posedge clk); #1;

    // ---- three wait states ----
    check("ws3/idle_stall", 32'(stall3), 32'h0);
    acc3("sw44",  1'b0, 1'b1, SW, 32'h44, 32'h0BAD_F00D, 32'h0);
    acc3("sw10",  1'b0, 1'b1, SW, 32'h10, 32'hCAFE_F00D, 32'h0);
    acc3("lw10",  1'b1, 1'b0, LW, 32'h10, 32'h0, 32'hCAFE_F00D);
    acc3("lw44",  1'b1, 1'b0, LW, 32'h44, 32'h0, 32'h0BAD_F00D);
    acc3("lh12",  1'b1, 1'b0, LH, 32'h12, 32'h0, 32'hFFFF_CAFE);
    // fault: same cycle, no stall, stays idle
    set_req(1'b1, 1'b0, LW, 32'h11, 32'h0);
    valid3 = 1'b1;
    @(negedge clk);
    check("ws3/f_lw11/fault", 32'(fault3), 32'h1);
    check("ws3/f_lw11/stall", 32'(stall3), 32'h0);
    check("ws3/f_lw11/rdata", rdata3, 32'h0);
    @(posedge clk); #1;
    valid3 = 1'b0;
    @(negedge clk);
    check("ws3/f_lw11/after", 32'(stall3), 32'h0);
    @(posedge clk); #1;

    // reset during a store aborts it
    acc3("sw40",  1'b0, 1'b1, SW, 32'h40, 32'h1111_1111, 32'h0);
    set_req(1'b0, 1'b1, SW, 32'h40, 32'h1234_5678);
    valid3 = 1'b1;
    @(negedge clk);
    check("abort/stall_c1", 32'(stall3), 32'h1);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    valid3 = 1'b0;
    @(negedge clk);
    check("abort/stall_after", 32'(stall3), 32'h0);
    check("abort/rdata_after", rdata3, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort/stall_idle", 32'(stall3), 32'h0);
    @(posedge clk); #1;
    acc3("lw40", 1'b1, 1'b0, LW, 32'h40, 32'h0, 32'h1111_1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
